// File: rtl/svo_stream_switch.sv
// svo_stream_switch
//   Frame-synchronous N:1 switch for SVO AXI video streams (tuser = start of frame).
//   One input at a time owns the downstream path; ownership only changes on a
//   frame boundary, so the output never carries a torn frame. Inputs that are
//   not granted are always ready and their pixels are discarded.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   sel_req           requested input index (values >= NUM_IN ignored)
//   in_axis_*         NUM_IN input streams, input i data at [i*BPP +: BPP]
//   out_axis_*        single output stream, one register stage
//   cur_sel           input currently granted
//   switch_done       one-cycle pulse when the first SOF of a new grant is accepted
//   frame_cnt         number of SOF pixels forwarded (wraps)
//
// state | meaning
// SYNC  | granted input chosen, waiting for its SOF; non-SOF pixels dropped
// RUN   | forwarding frames of the granted input; switch evaluated at each SOF
module svo_stream_switch #(
  parameter int SVO_BITS_PER_PIXEL = 24,
  parameter int NUM_IN             = 2,
  parameter int SEL_BITS           = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [SEL_BITS-1:0]                  sel_req,
  input  logic [NUM_IN-1:0]                    in_axis_tvalid,
  output logic [NUM_IN-1:0]                    in_axis_tready,
  input  logic [NUM_IN*SVO_BITS_PER_PIXEL-1:0] in_axis_tdata,
  input  logic [NUM_IN-1:0]                    in_axis_tuser,
  output logic                                 out_axis_tvalid,
  input  logic                                 out_axis_tready,
  output logic [SVO_BITS_PER_PIXEL-1:0]        out_axis_tdata,
  output logic                                 out_axis_tuser,
  output logic [SEL_BITS-1:0]                  cur_sel,
  output logic                                 switch_done,
  output logic [15:0]                          frame_cnt
);

  localparam int BPP = SVO_BITS_PER_PIXEL;

  localparam logic [0:0] ST_SYNC = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [SEL_BITS:0] NUM_IN_L = (SEL_BITS+1)'(NUM_IN);

  logic [0:0]          state;
  logic [SEL_BITS-1:0] sel_q;

  logic                sel_v;
  logic                sel_sof;
  logic [BPP-1:0]      sel_data;
  logic                ostall;
  logic                fwd;
  logic                rdy_s;
  logic                retarget;
  logic                load;

  always_comb begin
    sel_v    = 1'b0;
    sel_sof  = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (cur_sel == SEL_BITS'(i)) begin
        sel_v    = in_axis_tvalid[i];
        sel_sof  = in_axis_tuser[i];
        sel_data = in_axis_tdata[i*BPP +: BPP];
      end
    end
  end

  always_comb begin
    ostall   = out_axis_tvalid && !out_axis_tready;
    fwd      = 1'b0;
    rdy_s    = 1'b1;
    retarget = 1'b0;
    case (state)
      ST_SYNC: begin
        // A new request while still aligning abandons the current target;
        // its pixel this cycle is simply drained.
        if (sel_q != cur_sel) begin
          retarget = 1'b1;
        end else if (sel_sof) begin
          fwd   = sel_v;
          rdy_s = !ostall;
        end
      end
      ST_RUN: begin
        // The SOF that triggers a switch is left unconsumed; once cur_sel
        // moves away it is drained as an unselected input.
        if (sel_v && sel_sof && (sel_q != cur_sel)) begin
          retarget = 1'b1;
          rdy_s    = 1'b0;
        end else begin
          fwd   = sel_v;
          rdy_s = !ostall;
        end
      end
      default: begin
        fwd   = 1'b0;
        rdy_s = 1'b1;
      end
    endcase
    load = fwd && !ostall;
  end

  always_comb begin
    in_axis_tready = '1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (cur_sel == SEL_BITS'(i)) begin
        in_axis_tready[i] = rdy_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_SYNC;
      cur_sel         <= '0;
      sel_q           <= '0;
      out_axis_tvalid <= 1'b0;
      out_axis_tdata  <= '0;
      out_axis_tuser  <= 1'b0;
      switch_done     <= 1'b0;
      frame_cnt       <= '0;
    end else begin
      if ({1'b0, sel_req} < NUM_IN_L) begin
        sel_q <= sel_req;
      end

      switch_done <= 1'b0;
      if (retarget) begin
        cur_sel <= sel_q;
        state   <= ST_SYNC;
      end else if (load && (state == ST_SYNC)) begin
        state       <= ST_RUN;
        switch_done <= 1'b1;
      end

      if (load && sel_sof) begin
        frame_cnt <= frame_cnt + 16'd1;
      end

      if (load) begin
        out_axis_tvalid <= 1'b1;
        out_axis_tdata  <= sel_data;
        out_axis_tuser  <= sel_sof;
      end else if (out_axis_tready) begin
        out_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_svo_stream_switch.sv
module tb_svo_stream_switch;

  localparam int BPP = 24;
  localparam int NI  = 2;
  localparam int SB  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [SB-1:0]     sel_req;
  logic [NI-1:0]     in_axis_tvalid;
  logic [NI-1:0]     in_axis_tready;
  logic [NI*BPP-1:0] in_axis_tdata;
  logic [NI-1:0]     in_axis_tuser;
  logic              out_axis_tvalid;
  logic              out_axis_tready;
  logic [BPP-1:0]    out_axis_tdata;
  logic              out_axis_tuser;
  logic [SB-1:0]     cur_sel;
  logic              switch_done;
  logic [15:0]       frame_cnt;

  svo_stream_switch #(
    .SVO_BITS_PER_PIXEL(BPP),
    .NUM_IN(NI),
    .SEL_BITS(SB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sel_req(sel_req),
    .in_axis_tvalid(in_axis_tvalid),
    .in_axis_tready(in_axis_tready),
    .in_axis_tdata(in_axis_tdata),
    .in_axis_tuser(in_axis_tuser),
    .out_axis_tvalid(out_axis_tvalid),
    .out_axis_tready(out_axis_tready),
    .out_axis_tdata(out_axis_tdata),
    .out_axis_tuser(out_axis_tuser),
    .cur_sel(cur_sel),
    .switch_done(switch_done),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // source pixel queues: {sof, data}
  logic [BPP:0] src0[$];
  logic [BPP:0] src1[$];
  logic [BPP:0] exp_q[$];
  logic [NI-1:0] hs_q = '0;

  task automatic add_pix(input int i, input logic sof);
    logic [BPP:0] w;
    w = {sof, BPP'($urandom)};
    if (i == 0) src0.push_back(w);
    else        src1.push_back(w);
  endtask

  task automatic add_frame(input int i, input int n);
    for (int k = 0; k < n; k++) add_pix(i, (k == 0));
  endtask

  task automatic add_junk(input int i, input int n);
    for (int k = 0; k < n; k++) add_pix(i, 1'b0);
  endtask

  // sources: hold each pixel until handshake, random idle gaps
  initial begin
    logic [BPP:0] w;
    in_axis_tvalid = '0;
    in_axis_tuser  = '0;
    in_axis_tdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        if (in_axis_tvalid[i] && hs_q[i]) in_axis_tvalid[i] = 1'b0;
        if (!in_axis_tvalid[i] && ($urandom_range(3) != 0)) begin
          if (i == 0 && src0.size() > 0) begin
            w = src0.pop_front();
            in_axis_tvalid[i] = 1'b1;
          end else if (i == 1 && src1.size() > 0) begin
            w = src1.pop_front();
            in_axis_tvalid[i] = 1'b1;
          end
          if (in_axis_tvalid[i]) begin
            in_axis_tuser[i]            = w[BPP];
            in_axis_tdata[i*BPP +: BPP] = w[BPP-1:0];
          end
        end
      end
    end
  end

  // reference model: frame-level grant bookkeeping driven by observed handshakes
  int          m_g      = 0;
  int          m_sel_q  = 0;
  bit          m_locked = 0;
  bit          m_done   = 0;
  logic [15:0] m_frames = '0;
  bit          started  = 0;
  bit          after_rst = 0;
  bit          prev_stall = 0;
  logic [BPP:0] prev_out;

  initial begin
    logic [BPP:0] e;
    bit vg, sg;
    forever begin
      @(negedge clk);
      hs_q = in_axis_tvalid & in_axis_tready;
      if (reset) begin
        exp_q.delete();
        m_g = 0; m_sel_q = 0; m_locked = 0; m_done = 0; m_frames = '0;
        prev_stall = 0;
        started = 1;
        after_rst = 1;
      end else if (started) begin
        if (after_rst) begin
          chk("rst_out_valid", 32'(out_axis_tvalid), 32'd0);
          chk("rst_out_user_data", {7'd0, out_axis_tuser, out_axis_tdata}, 32'd0);
          after_rst = 0;
        end
        if (prev_stall) begin
          chk("stall_hold", {6'd0, out_axis_tvalid, out_axis_tuser, out_axis_tdata},
              {6'd0, 1'b1, prev_out});
        end
        chk("cur_sel", 32'(cur_sel), 32'(m_g));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
        chk("switch_done", 32'(switch_done), 32'(m_done));
        for (int i = 0; i < NI; i++)
          if (i != m_g) chk("unsel_ready", 32'(in_axis_tready[i]), 32'd1);

        if (out_axis_tvalid && out_axis_tready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out: got %0h expected none", {out_axis_tuser, out_axis_tdata});
          end else begin
            e = exp_q.pop_front();
            chk("out_pixel", 32'({out_axis_tuser, out_axis_tdata}), 32'(e));
          end
        end
        prev_stall = out_axis_tvalid && !out_axis_tready;
        prev_out   = {out_axis_tuser, out_axis_tdata};

        m_done = 0;
        vg = in_axis_tvalid[m_g];
        sg = in_axis_tuser[m_g];
        if (m_locked && vg && sg && (m_sel_q != m_g)) begin
          chk("switch_sof_held", 32'(in_axis_tready[m_g]), 32'd0);
          m_g = m_sel_q;
          m_locked = 0;
        end else if (!m_locked && (m_sel_q != m_g)) begin
          m_g = m_sel_q;
        end else if (hs_q[m_g]) begin
          if (m_locked || sg) begin
            exp_q.push_back({sg, in_axis_tdata[m_g*BPP +: BPP]});
            if (sg) m_frames = m_frames + 16'd1;
            if (!m_locked) begin
              m_locked = 1;
              m_done = 1;
            end
          end
        end
        if (int'(sel_req) < NI) m_sel_q = int'(sel_req);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sel_mode: 0 hold, 1 only out-of-range values, 2 any value
  task automatic wait_drain(input int max_cyc, input bit rnd_ready, input int sel_mode);
    int n = 0;
    while (!(src0.size() == 0 && src1.size() == 0 && in_axis_tvalid == '0 &&
             exp_q.size() == 0 && !out_axis_tvalid) && n < max_cyc) begin
      if (rnd_ready) out_axis_tready = $urandom_range(1);
      if (sel_mode == 1) sel_req = SB'(2 + $urandom_range(1));
      if (sel_mode == 2 && $urandom_range(7) == 0) sel_req = SB'($urandom_range(3));
      tick();
      n++;
    end
    out_axis_tready = 1'b1;
    checks++;
    if (n >= max_cyc) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    repeat (3) tick();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    sel_req = '0;
    out_axis_tready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // junk then 4x2 frame on input 0
    add_junk(0, 3);
    add_frame(0, 8);
    wait_drain(300, 0, 0);
    chk("frames_after_first", 32'(frame_cnt), 32'd1);

    // mid-frame switch request to input 1
    add_frame(0, 16);
    add_frame(0, 16);
    add_junk(1, 5);
    for (int k = 0; k < 4; k++) add_frame(1, 16);
    n = 0;
    while (src0.size() > 28 && n < 200) begin tick(); n++; end
    sel_req = 2'd1;
    wait_drain(1000, 0, 0);
    chk("sel_after_switch", 32'(cur_sel), 32'd1);

    // back-pressure on a long frame
    add_frame(1, 64);
    add_frame(0, 64);
    wait_drain(2000, 1, 0);

    // back to input 0, then out-of-range requests
    sel_req = 2'd0;
    add_frame(1, 8);
    add_junk(0, 4);
    add_frame(0, 8);
    wait_drain(500, 0, 0);
    add_frame(0, 20); add_frame(1, 20); add_frame(0, 20);
    wait_drain(1000, 1, 1);
    chk("sel_ignored", 32'(cur_sel), 32'd0);

    // request pulse that reverts before the next SOF
    sel_req = 2'd0;
    add_frame(0, 40);
    add_frame(0, 8);
    add_frame(1, 40);
    repeat (10) tick();
    sel_req = 2'd1;
    tick();
    sel_req = 2'd0;
    wait_drain(1000, 0, 0);
    chk("sel_no_switch", 32'(cur_sel), 32'd0);

    // reset mid-frame with a stalled output pixel
    add_frame(0, 30);
    repeat (8) tick();
    out_axis_tready = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_axis_tready = 1'b1;
    add_frame(0, 8);
    wait_drain(1000, 0, 0);

    // randomized traffic and selection
    for (int k = 0; k < 6; k++) begin
      add_junk(1, $urandom_range(5));
      add_frame(0, $urandom_range(4, 20));
      add_frame(1, $urandom_range(4, 20));
      add_frame(0, $urandom_range(4, 20));
      wait_drain(2000, 1, 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/svo_stream_switch.md
Name: svo_stream_switch

Overview:
- Frame-synchronous N:1 scheduler for SVO AXI video streams (tuser[0] = start of frame).
- Grants the single downstream video path to one input stream at a time. Selection changes only on frame boundaries, so the output never carries a partial or torn frame.
- Inputs that are not granted are drained (always ready, pixels discarded) so upstream sources never stall.
- Sits between camera/pattern sources and the overlay/output pipeline.

Parameters:
- SVO_BITS_PER_PIXEL, 24, pixel width.
- NUM_IN, 2, number of input streams (2..4).
- SEL_BITS, 1, width of the select field; must satisfy 2**SEL_BITS >= NUM_IN.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- sel_req  in  SEL_BITS  requested input index; values >= NUM_IN are ignored.
- in_axis_tvalid  in  NUM_IN  per-input valid.
- in_axis_tready  out  NUM_IN  per-input ready.
- in_axis_tdata  in  NUM_IN*SVO_BITS_PER_PIXEL  input i occupies slice [i*BPP +: BPP].
- in_axis_tuser  in  NUM_IN  per-input start of frame.
- out_axis_tvalid  out  1  output valid.
- out_axis_tready  in  1  output ready.
- out_axis_tdata  out  SVO_BITS_PER_PIXEL  output pixel.
- out_axis_tuser  out  1  output start of frame.
- cur_sel  out  SEL_BITS  input currently granted.
- switch_done  out  1  one-cycle pulse when the first SOF of a newly granted input is accepted.
- frame_cnt  out  16  count of SOF pixels forwarded; wraps at 65535 -> 0.

Behaviour:
- Reset values: cur_sel=0, state=SYNC, sel_q=0, out_axis_tvalid=0, out_axis_tdata=0, out_axis_tuser=0, switch_done=0, frame_cnt=0.
- Reset asserted mid-frame discards the partial frame. Any pixel held in the output register is dropped.
- sel_req is registered into sel_q every cycle if sel_req < NUM_IN; otherwise sel_q holds its value. All decisions use sel_q, so sel_req takes effect 1 cycle after it is presented.
- Output register: one stage. Define ostall = out_axis_tvalid && !out_axis_tready.
  - Load occurs when fwd=1 and !ostall.
  - If out_axis_tready=1 and there is no load, out_axis_tvalid clears.
  - tdata and tuser hold while ostall.
- Latency: an accepted input pixel appears on the output the next cycle.
- Let s=cur_sel, v=in_axis_tvalid[s], sof=in_axis_tuser[s].
- Unselected inputs (i != s): in_axis_tready[i]=1 at all times; their pixels are discarded.
- State SYNC (aligning to the granted input):
  - sof=0: in_axis_tready[s]=1, pixel dropped.
  - sof=1: fwd=1 and in_axis_tready[s]=!ostall. On acceptance: go RUN, pulse switch_done, frame_cnt+1.
- State RUN:
  - Switch check: if v && sof && sel_q != s, the SOF pixel is NOT consumed (in_axis_tready[s]=0 that cycle). Then cur_sel<=sel_q, go SYNC. The old input's SOF pixel is drained on the next cycle as an unselected input.
  - Otherwise: fwd=v, in_axis_tready[s]=!ostall. frame_cnt increments on each accepted SOF.
- Switch request arriving mid-frame: the current frame completes; the switch happens at the next SOF of the current input.
- Request reverting to s before that SOF: no switch and no pulse.
- sel_q == s in SYNC: no effect; SYNC continues.
- In SYNC, the switch check uses the new input only. A second change of sel_q during SYNC retargets cur_sel immediately (cur_sel<=sel_q, stay SYNC), with no pulse.
- Back-pressure never drops pixels in RUN: the granted input stalls. A stall in SYNC while an SOF is waiting holds that SOF.
- switch_done also pulses on the first frame after reset.
- Output tvalid never depends combinationally on out_axis_tready.

Test Plan:
- Reset, feed input 0 with 3 junk pixels (tuser=0), then a 4x2 frame starting with SOF, out_tready=1 -> junk dropped; 8 pixels out with tuser[0] on the first only; 1-cycle latency; switch_done pulses once; frame_cnt=1.
- Streaming input 0; set sel_req=1 at pixel 3 of a 16-pixel frame; input 1 running mid-frame -> input 0 frame completes all 16 pixels; input 0's next SOF not forwarded; cur_sel=1; input 1 pixels dropped until its SOF; then switch_done pulses and input 1 frame is forwarded.
- Toggle out_axis_tready randomly (50%) during a 64-pixel frame -> output sequence equals input sequence exactly, no duplicates or losses; unselected input tready remains 1 throughout.
- sel_req=3 with NUM_IN=2 -> ignored; cur_sel stays 0; no switch.
- sel_req pulses 0->1->0 within one frame -> no switch; switch_done stays 0.
- Assert reset for 1 cycle mid-frame with out_tvalid=1 held by tready=0 -> out_axis_tvalid=0 next cycle; cur_sel=0; state SYNC; frame_cnt=0; output resumes only at the next input 0 SOF.
